adder_tree_arbiter: RTL
=======================

ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the WAIT-state cycle limit (used only when TIMEOUT_EN is defined).
REQ-002 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req  input  4  per-requester request, level, held until granted.
REQ-005 The block SHALL have port req_din  input  512  requester i operand vector in bits [128*i+127:128*i].
REQ-006 The block SHALL have port gnt  output  4  one-hot, one-cycle grant pulse.
REQ-007 The block SHALL have port rsp_valid  output  4  one-hot, one-cycle response pulse to the granted requester.
REQ-008 The block SHALL have port rsp_data  output  16  result, valid only while any rsp_valid bit is high, else 0.
REQ-009 The block SHALL have port rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-010 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 The block SHALL have port tree_start  output  1  one-cycle start pulse to the adder tree.
REQ-012 The block SHALL have port tree_din  output  128  operand vector to the adder tree, held stable from ISSUE through WAIT.
REQ-013 The block SHALL have port tree_done  input  1  adder tree completion pulse.
REQ-014 The block SHALL have port tree_dout  input  16  adder tree result, valid while tree_done is high.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, and SHALL reset to IDLE.
REQ-016 In IDLE with req != 0, the block SHALL select winner w by round-robin starting at pointer p, capture req_din slice w into an operand register, and move to ISSUE; with req == 0 it SHALL remain in IDLE.
REQ-017 In ISSUE (exactly one cycle), the block SHALL drive gnt[w]=1 and tree_start=1, drive tree_din from the operand register, set p=(w+1) mod 4, and move to WAIT.
REQ-018 In WAIT, the block SHALL hold tree_din; on tree_done=1 it SHALL capture tree_dout and move to RESP.
REQ-019 In RESP (exactly one cycle), the block SHALL drive rsp_valid[w]=1 and rsp_data=captured result, then move to IDLE.
REQ-020 tree_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-021 req SHALL be sampled only in IDLE; a request dropped before its grant is discarded without side effects.
REQ-022 The same requester MAY be granted again in the cycle after RESP if it is the only requester.
REQ-023 Latency: with tree_done arriving L cycles after tree_start, rsp_valid SHALL assert L+2 cycles after the IDLE cycle in which req was sampled.
REQ-024 rsp_data SHALL be passed through unmodified; 16-bit wrap-around is owned by the adder tree.
REQ-025 gnt, rsp_valid, tree_start and rsp_data SHALL be 0 in all states other than those defined above.

Reset
REQ-026 While rstn=0, the block SHALL set state=IDLE, p=0, operand and result registers to 0, and all outputs to 0.
REQ-027 Reset during WAIT SHALL abandon the transaction with no rsp_valid; a tree_done arriving after reset SHALL be ignored.

Configuration
REQ-028 With macro ADDER_TREE_ARBITER_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle; at count TIMEOUT_CYCLES without tree_done, the block SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-029 With ADDER_TREE_ARBITER_TIMEOUT_EN undefined, no counter SHALL exist, WAIT SHALL persist until tree_done, and rsp_err SHALL be constant 0.

Verification
REQ-030 Single request: req=4'b0001, all eight lanes=16'h0001, tree model L=4 -> gnt=0001 at cycle 1, tree_start at cycle 1, rsp_valid=0001 and rsp_data=16'h0008 at cycle 6.
REQ-031 Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0, each grant one-hot.
REQ-032 Wrap: requester 2 with all lanes=16'hFFFF -> rsp_valid=0100, rsp_data=16'hFFF8.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=16): tree_done never asserted -> rsp_valid with rsp_err=1 and rsp_data=0 after 16 WAIT cycles, then IDLE.
REQ-034 Reset mid-WAIT: assert rstn=0 two cycles after tree_start, release, pulse tree_done -> no rsp_valid, busy=0, and the next grant goes to requester 0.
REQ-035 Spurious done: tree_done pulsed in IDLE -> no state change and all outputs remain 0.

Source files
------------

// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter fronting a shared multi-cycle adder tree.
// Optional WAIT timeout: define ADDER_TREE_ARBITER_TIMEOUT_EN.
module adder_tree_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [3:0]   req,
   input  logic [511:0] req_din,
   output logic [3:0]   gnt,
   output logic [3:0]   rsp_valid,
   output logic [15:0]  rsp_data,
   output logic         rsp_err,
   output logic         busy,
   output logic         tree_start,
   output logic [127:0] tree_din,
   input  logic         tree_done,
   input  logic [15:0]  tree_dout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state_q;
   logic [1:0]     p_q;
   logic [1:0]     win_q;
   logic [1:0]     win_d;
   logic [1:0]     idx_d;
   logic           found_d;
   logic [127:0]   opnd_q;
   logic [3:0]     gnt_q;
   logic           start_q;
   logic [3:0]     rsp_valid_q;
   logic [15:0]    rsp_data_q;

`ifdef ADDER_TREE_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]  cnt_q;
   logic           rsp_err_q;
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign gnt        = gnt_q;
   assign tree_start = start_q;
   assign tree_din   = opnd_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = (state_q != S_IDLE);

   // Round-robin pick: first requester at or after the pointer
   always_comb begin
      win_d   = p_q;
      idx_d   = '0;
      found_d = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx_d = p_q + 2'(k);
         if (!found_d && req[idx_d]) begin
            win_d   = idx_d;
            found_d = 1'b1;
         end
      end
   end

   // Transaction FSM with registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         p_q         <= '0;
         win_q       <= '0;
         opnd_q      <= '0;
         gnt_q       <= '0;
         start_q     <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
`ifdef ADDER_TREE_ARBITER_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (|req) begin
                  win_q   <= win_d;
                  opnd_q  <= req_din[{win_d, 7'd0} +: 128];
                  gnt_q   <= 4'b0001 << win_d;
                  start_q <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               gnt_q   <= '0;
               start_q <= 1'b0;
               p_q     <= win_q + 2'd1;
               state_q <= S_WAIT;
`ifdef ADDER_TREE_ARBITER_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_WAIT: begin
               if (tree_done) begin
                  rsp_data_q  <= tree_dout;
                  rsp_valid_q <= 4'b0001 << win_q;
                  state_q     <= S_RESP;
               end
`ifdef ADDER_TREE_ARBITER_TIMEOUT_EN
               else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data_q  <= '0;
                  rsp_valid_q <= 4'b0001 << win_q;
                  rsp_err_q   <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
`endif
            end
            S_RESP: begin
               rsp_valid_q <= '0;
               rsp_data_q  <= '0;
`ifdef ADDER_TREE_ARBITER_TIMEOUT_EN
               rsp_err_q   <= 1'b0;
`endif
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
